// File: rtl/resp_framer.sv
// resp_framer: serialises Modbus RTU responses (exception, register read, write echo) with CRC-16/MODBUS.
// Define RS485_DE_EN to add RS-485 driver-enable lead/hold timing around each frame.
module resp_framer #(
  parameter logic [7:0]  SADDR   = 8'h01,
  parameter int unsigned DE_HOLD = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        handler_done,
  input  logic [7:0]  func_code_r,
  input  logic [15:0] addr_r,
  input  logic [15:0] data_r,
  input  logic [7:0]  tx_quantity,
  input  logic [7:0]  exception_out,
  output logic [7:0]  dpram_raddr,
  input  logic [15:0] dpram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        rs485_de
);

  typedef enum logic [2:0] {IDLE, LATCH, FETCH, SEND, WAIT, CRC_LO, CRC_HI, DONE} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_func, r_qty, r_exc;
  logic [15:0] r_addr, r_data, r_crc;
  logic [7:0]  r_byte_cnt, r_word_idx, r_tx_data;
  logic [1:0]  r_phase;

  logic        w_is_rd_func, w_is_exc, w_is_read, w_is_write, w_has_frame, w_launch;
  logic [7:0]  w_exc_code, w_len, w_byte;

`ifdef RS485_DE_EN
  localparam logic [15:0] HOLD_LAST = 16'(DE_HOLD - 1);
  localparam logic [15:0] HOLD_CLR  = 16'(DE_HOLD - 2);
  logic [1:0]  r_dly;
  logic [15:0] r_hold;
  logic        r_de;
`else
  logic        w_unused_hold;
  assign w_unused_hold = (DE_HOLD == 0);
`endif

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  // Frame type and payload length (bytes before the CRC) from the latched request.
  always_comb begin
    w_is_rd_func = (r_func == 8'h03) || (r_func == 8'h04);
    w_is_exc     = (r_exc != 8'h00) || (w_is_rd_func && (r_qty > 8'd125));
    w_exc_code   = (r_exc != 8'h00) ? r_exc : 8'h04;
    w_is_read    = !w_is_exc && w_is_rd_func;
    w_is_write   = !w_is_exc && (r_func == 8'h06);
    w_has_frame  = w_is_exc || w_is_read || w_is_write;
    w_len        = 8'd6;
    if (w_is_exc)       w_len = 8'd3;
    else if (w_is_read) w_len = 8'd3 + {r_qty[6:0], 1'b0};
  end

  always_comb begin
    w_byte = SADDR;
    if (r_byte_cnt == 8'd0) begin
      w_byte = SADDR;
    end else if (w_is_exc) begin
      w_byte = (r_byte_cnt == 8'd1) ? (r_func | 8'h80) : w_exc_code;
    end else if (w_is_write) begin
      case (r_byte_cnt)
        8'd1:    w_byte = r_func;
        8'd2:    w_byte = r_addr[15:8];
        8'd3:    w_byte = r_addr[7:0];
        8'd4:    w_byte = r_data[15:8];
        default: w_byte = r_data[7:0];
      endcase
    end else if (r_byte_cnt == 8'd1) begin
      w_byte = r_func;
    end else if (r_byte_cnt == 8'd2) begin
      w_byte = {r_qty[6:0], 1'b0};
    end else begin
      w_byte = r_byte_cnt[0] ? dpram_rdata[15:8] : dpram_rdata[7:0];
    end
  end

`ifdef RS485_DE_EN
  assign w_launch   = w_has_frame && (r_dly == 2'd2);
  assign frame_done = (r_state == DONE) && (r_hold == HOLD_LAST);
  assign rs485_de   = r_de;
`else
  assign w_launch   = w_has_frame;
  assign frame_done = (r_state == DONE);
  assign rs485_de   = 1'b0;
`endif

  assign tx_start    = (r_state == SEND);
  assign busy        = (r_state != IDLE);
  assign tx_data     = r_tx_data;
  assign dpram_raddr = r_word_idx;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (handler_done) w_next = LATCH;
      LATCH: begin
        if (!w_has_frame)  w_next = IDLE;
        else if (w_launch) w_next = SEND;
      end
      FETCH, CRC_LO, CRC_HI: w_next = SEND;
      SEND:  w_next = WAIT;
      WAIT: begin
        if (tx_done) begin
          case (r_phase)
            2'd0:    w_next = (r_byte_cnt < w_len) ? FETCH : CRC_LO;
            2'd1:    w_next = CRC_HI;
            default: w_next = DONE;
          endcase
        end
      end
`ifdef RS485_DE_EN
      DONE:  if (r_hold == HOLD_LAST) w_next = IDLE;
`else
      DONE:  w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Request fields are captured on the same edge that accepts handler_done.
  // The word index doubles as the read address so the next word is on the bus during WAIT.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_func     <= 8'h00;
      r_qty      <= 8'h00;
      r_exc      <= 8'h00;
      r_addr     <= 16'h0000;
      r_data     <= 16'h0000;
      r_crc      <= 16'hFFFF;
      r_byte_cnt <= 8'h00;
      r_word_idx <= 8'h00;
      r_tx_data  <= 8'h00;
      r_phase    <= 2'd0;
`ifdef RS485_DE_EN
      r_dly      <= 2'd0;
      r_hold     <= 16'h0000;
      r_de       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (handler_done) begin
            r_func     <= func_code_r;
            r_qty      <= tx_quantity;
            r_exc      <= exception_out;
            r_addr     <= addr_r;
            r_data     <= data_r;
            r_crc      <= 16'hFFFF;
            r_byte_cnt <= 8'h00;
            r_word_idx <= 8'h00;
            r_phase    <= 2'd0;
`ifdef RS485_DE_EN
            r_dly      <= 2'd0;
            r_hold     <= 16'h0000;
`endif
          end
        end
        LATCH: begin
          r_tx_data <= w_byte;
`ifdef RS485_DE_EN
          r_dly <= r_dly + 2'd1;
          if (w_has_frame) r_de <= 1'b1;
`endif
        end
        FETCH: r_tx_data <= w_byte;
        CRC_LO: begin
          r_tx_data <= r_crc[7:0];
          r_phase   <= 2'd1;
        end
        CRC_HI: begin
          r_tx_data <= r_crc[15:8];
          r_phase   <= 2'd2;
        end
        SEND: begin
          if (r_phase == 2'd0) begin
            r_crc      <= crc16_byte(r_crc, r_tx_data);
            r_byte_cnt <= r_byte_cnt + 8'd1;
            if (w_is_read && (r_byte_cnt >= 8'd4) && !r_byte_cnt[0]) r_word_idx <= r_word_idx + 8'd1;
          end
        end
`ifdef RS485_DE_EN
        WAIT: begin
          r_hold <= 16'h0000;
          if (tx_done && (r_phase == 2'd2) && (DE_HOLD <= 1)) r_de <= 1'b0;
        end
        DONE: begin
          r_hold <= r_hold + 16'd1;
          if (r_hold == HOLD_CLR) r_de <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_resp_framer.sv
// tb_resp_framer: drives resp_framer with a UART/DPRAM model and compares every transmitted byte
// against a frame model built directly from the Modbus response rules.
module tb_resp_framer;

  localparam logic [7:0] SADDR_TB   = 8'h01;
  localparam int         DE_HOLD_TB = 5;
`ifdef RS485_DE_EN
  localparam int         LAT = 4;
`else
  localparam int         LAT = 2;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        handler_done = 1'b0;
  logic [7:0]  func_code_r = 8'h00;
  logic [15:0] addr_r = 16'h0000;
  logic [15:0] data_r = 16'h0000;
  logic [7:0]  tx_quantity = 8'h00;
  logic [7:0]  exception_out = 8'h00;
  logic [7:0]  dpram_raddr;
  logic [15:0] dpram_rdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        rs485_de;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lastDoneCyc = 0;

  logic [15:0] mem [0:255];
  logic [7:0]  rxq [$];
  logic [7:0]  expQ [$];

  logic        uartBusy = 1'b0;
  int          uartCnt = 0;
  logic [7:0]  heldByte = 8'h00;

  resp_framer #(.SADDR(SADDR_TB), .DE_HOLD(DE_HOLD_TB)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .handler_done(handler_done),
    .func_code_r(func_code_r), .addr_r(addr_r), .data_r(data_r),
    .tx_quantity(tx_quantity), .exception_out(exception_out),
    .dpram_raddr(dpram_raddr), .dpram_rdata(dpram_rdata),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .frame_done(frame_done), .rs485_de(rs485_de)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  // Synchronous-read DPRAM: data follows the address one cycle later.
  always @(posedge clk_in) dpram_rdata <= mem[dpram_raddr];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART model: captures each started byte, answers with tx_done after 1..4 cycles,
  // and throws stray tx_done pulses while no byte is outstanding.
  always @(negedge clk_in) begin
    tx_done = 1'b0;
    if (!rst_n_in) begin
      uartBusy = 1'b0;
      uartCnt  = 0;
    end else if (tx_start) begin
      checkOutput("uart.startWhileBusy", 32'(uartBusy), 32'd0);
      rxq.push_back(tx_data);
      heldByte = tx_data;
      uartBusy = 1'b1;
      uartCnt  = int'($urandom_range(1, 4));
    end else if (uartBusy) begin
      checkOutput("uart.dataStable", 32'(tx_data), 32'(heldByte));
      uartCnt--;
      if (uartCnt == 0) begin
        tx_done     = 1'b1;
        uartBusy    = 1'b0;
        lastDoneCyc = cyc;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      tx_done = 1'b1;
    end
  end

  task automatic pushBytes(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, input int n);
    logic [7:0] b [8];
    b = '{b0, b1, b2, b3, b4, b5, b6, b7};
    expQ.delete();
    for (int i = 0; i < n; i++) expQ.push_back(b[i]);
  endtask

  // Expected response built from the framing rules, then CRC-16/MODBUS appended low byte first.
  task automatic buildExpected(input logic [7:0] f, e, q, input logic [15:0] a, d);
    logic [15:0] crc;
    int qi;
    qi = int'(q);
    expQ.delete();
    if (e != 8'h00 || ((f == 8'h03 || f == 8'h04) && qi > 125)) begin
      expQ.push_back(SADDR_TB);
      expQ.push_back(f | 8'h80);
      expQ.push_back((e != 8'h00) ? e : 8'h04);
    end else if (f == 8'h03 || f == 8'h04) begin
      expQ.push_back(SADDR_TB);
      expQ.push_back(f);
      expQ.push_back(8'(2 * qi));
      for (int i = 0; i < qi; i++) begin
        expQ.push_back(mem[i][15:8]);
        expQ.push_back(mem[i][7:0]);
      end
    end else if (f == 8'h06) begin
      expQ.push_back(SADDR_TB);
      expQ.push_back(8'h06);
      expQ.push_back(a[15:8]);
      expQ.push_back(a[7:0]);
      expQ.push_back(d[15:8]);
      expQ.push_back(d[7:0]);
    end
    if (expQ.size() > 0) begin
      crc = 16'hFFFF;
      foreach (expQ[i]) begin
        crc = crc ^ {8'h00, expQ[i]};
        for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
      end
      expQ.push_back(crc[7:0]);
      expQ.push_back(crc[15:8]);
    end
  endtask

  // One request/response exchange, checked against expQ.
  task automatic applyStimulus(input logic [7:0] f, e, q, input logic [15:0] a, d,
                               input bit glitch, input string name);
    int n, fdCount, firstStart, fdCyc, busyCycles, deRise, deFall;
    bit timedOut;
    rxq.delete();
    @(negedge clk_in);
    func_code_r = f; exception_out = e; tx_quantity = q; addr_r = a; data_r = d;
    handler_done = 1'b1;
    @(negedge clk_in);
    handler_done = 1'b0;
    func_code_r = 8'($urandom); exception_out = 8'($urandom); tx_quantity = 8'($urandom);
    addr_r = 16'($urandom); data_r = 16'($urandom);
    n = 1; fdCount = 0; firstStart = -1; fdCyc = -1; deRise = -1; deFall = -1;
    busyCycles = busy ? 1 : 0;
    timedOut = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk_in);
      n++;
      if (glitch && n == 6) begin
        handler_done = 1'b1; func_code_r = 8'h06; exception_out = 8'h00;
      end else begin
        handler_done = 1'b0;
      end
      if (tx_start && firstStart < 0) firstStart = n;
      if (frame_done) begin fdCount++; fdCyc = cyc; end
      if (rs485_de && deRise < 0) deRise = n;
      if (!rs485_de && deRise >= 0 && deFall < 0) deFall = cyc;
      if (busy) busyCycles++;
      else begin timedOut = 1'b0; break; end
    end
    handler_done = 1'b0;
    repeat (4) @(negedge clk_in);
    checkOutput({name, ".timeout"}, 32'(timedOut), 32'd0);
    checkOutput({name, ".byteCount"}, 32'(rxq.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      checkOutput($sformatf("%s.byte%0d", name, i), (i < rxq.size()) ? 32'(rxq[i]) : 32'h1FF, 32'(expQ[i]));
    checkOutput({name, ".frameDone"}, 32'(fdCount), (expQ.size() > 0) ? 32'd1 : 32'd0);
    checkOutput({name, ".firstStart"}, 32'(firstStart), (expQ.size() > 0) ? 32'(LAT) : 32'hFFFFFFFF);
    if (expQ.size() == 0) begin
      checkOutput({name, ".busyCycles"}, 32'(busyCycles), 32'd1);
    end else begin
`ifdef RS485_DE_EN
      checkOutput({name, ".deLead"}, 32'(firstStart - deRise), 32'd2);
      checkOutput({name, ".deHold"}, 32'(deFall - lastDoneCyc), 32'(DE_HOLD_TB));
      checkOutput({name, ".doneAtDeFall"}, 32'(fdCyc), 32'(deFall));
`else
      checkOutput({name, ".deLow"}, 32'(deRise), 32'hFFFFFFFF);
      checkOutput({name, ".doneLag"}, 32'(fdCyc - lastDoneCyc), 32'd1);
`endif
    end
  endtask

  initial begin
    logic [7:0] f, e, q;
    int pick, guard, spur;

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    repeat (2) @(negedge clk_in);
    checkOutput("reset.tx_start", 32'(tx_start), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset.rs485_de", 32'(rs485_de), 32'd0);
    checkOutput("reset.tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset.dpram_raddr", 32'(dpram_raddr), 32'd0);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    $display("[TB] exception frame");
    pushBytes(8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1, 8'h00, 8'h00, 8'h00, 5);
    applyStimulus(8'h03, 8'h02, 8'h04, 16'h0000, 16'h0000, 1'b0, "exc");

    $display("[TB] write echo");
    pushBytes(8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B, 8);
    applyStimulus(8'h06, 8'h00, 8'h00, 16'h0001, 16'h0003, 1'b0, "wr");

    $display("[TB] read four registers");
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    buildExpected(8'h04, 8'h00, 8'd4, 16'h0000, 16'h0000);
    applyStimulus(8'h04, 8'h00, 8'd4, 16'h0000, 16'h0000, 1'b0, "rd4");

    buildExpected(8'h03, 8'h00, 8'd0, 16'h0000, 16'h0000);
    applyStimulus(8'h03, 8'h00, 8'd0, 16'h0000, 16'h0000, 1'b0, "qty0");

    buildExpected(8'h03, 8'h00, 8'd200, 16'h0000, 16'h0000);
    applyStimulus(8'h03, 8'h00, 8'd200, 16'h0000, 16'h0000, 1'b0, "qty200");

    buildExpected(8'h04, 8'h00, 8'd125, 16'h0000, 16'h0000);
    applyStimulus(8'h04, 8'h00, 8'd125, 16'h0000, 16'h0000, 1'b0, "qty125");

    expQ.delete();
    applyStimulus(8'h05, 8'h00, 8'd3, 16'h1234, 16'h5678, 1'b0, "fc05");

    $display("[TB] handler_done while busy");
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    buildExpected(8'h03, 8'h00, 8'd6, 16'h0000, 16'h0000);
    applyStimulus(8'h03, 8'h00, 8'd6, 16'h0000, 16'h0000, 1'b1, "glitch");

    $display("[TB] reset mid-frame");
    rxq.delete();
    @(negedge clk_in);
    func_code_r = 8'h04; exception_out = 8'h00; tx_quantity = 8'd8; handler_done = 1'b1;
    @(negedge clk_in);
    handler_done = 1'b0;
    guard = 0;
    while (rxq.size() < 3 && guard < 500) begin
      @(negedge clk_in);
      guard++;
    end
    checkOutput("rst.reachByte3", 32'(guard < 500), 32'd1);
    rst_n_in = 1'b0;
    #1;
    checkOutput("rst.tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst.rs485_de", 32'(rs485_de), 32'd0);
    checkOutput("rst.tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst.dpram_raddr", 32'(dpram_raddr), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    spur = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (tx_start || frame_done || busy) spur++;
    end
    checkOutput("rst.quietAfter", 32'(spur), 32'd0);
    buildExpected(8'h04, 8'h00, 8'd3, 16'h0000, 16'h0000);
    applyStimulus(8'h04, 8'h00, 8'd3, 16'h0000, 16'h0000, 1'b0, "postRst");

    $display("[TB] randomized frames");
    for (int t = 0; t < 14; t++) begin
      pick = int'($urandom_range(0, 9));
      f = (pick < 3) ? 8'h03 : (pick < 6) ? 8'h04 : (pick < 8) ? 8'h06 : 8'($urandom);
      e = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      q = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(120, 255)) : 8'($urandom_range(0, 16));
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      buildExpected(f, e, q, 16'($urandom), 16'h0000);
      addr_r = (expQ.size() == 10 && f == 8'h06) ? {expQ[2], expQ[3]} : 16'h0000;
      applyStimulus(f, e, q, (f == 8'h06 && e == 8'h00) ? {expQ[2], expQ[3]} : 16'h0000,
                    (f == 8'h06 && e == 8'h00) ? {expQ[4], expQ[5]} : 16'h0000, 1'b0, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
